// File: rtl/wos_output_writer.sv
// ----------------------------------------------------------------------------
// wos_output_writer
//
// Write-side counterpart of the window read-address scanner. The scanner
// walks every image row over columns 0..w+k-1 (k = n>>1) and emits one
// filter result per column position. This block takes that stream over a
// valid/ready handshake, drops the k leading partial-window results of each
// row, and writes the remaining w results per row to output memory at the
// row-major address row*w + (col-k). After h rows it reports completion.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-low reset
//   start      one-cycle pulse; latches h, w, n (honoured in IDLE or DONE)
//   h, w       image height / width
//   n          window length; k = n>>1 leading results per row are dropped
//   in_valid   filter result valid
//   in_data    filter result
//   in_ready   block accepts in_data this cycle
//   mem_we     write request valid (single-entry output register)
//   mem_addr   write address
//   mem_wdata  write data
//   mem_ready  memory accepts the write this cycle
//   busy       frame in progress (RUN or DRAIN)
//   done       frame complete; held until the next start
// ----------------------------------------------------------------------------
module wos_output_writer #(
    parameter  int WORD   = 32,
    parameter  int MAX_N  = 25,
    localparam int N_BITS = $clog2(MAX_N),
    localparam int K_BITS = $clog2(MAX_N >> 1) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD-1:0]   h,
    input  logic [WORD-1:0]   w,
    input  logic [N_BITS-1:0] n,
    input  logic              in_valid,
    input  logic [WORD-1:0]   in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [WORD-1:0]   mem_addr,
    output logic [WORD-1:0]   mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [WORD-1:0]   h_r;
    logic [WORD-1:0]   w_r;
    logic [K_BITS-1:0] k_r;
    logic [WORD-1:0]   col;       // column position within the scanned row
    logic [WORD-1:0]   row;       // current image row
    logic [WORD-1:0]   row_base;  // row * w_r, kept as a running sum

    logic [WORD-1:0]   k_ext;
    logic [WORD-1:0]   end_col;
    logic              accept;
    logic              retire;
    logic              drop;
    logic              row_end;
    logic              last_row;
    logic              load;

    assign k_ext    = WORD'(k_r);
    assign end_col  = w_r + k_ext - WORD'(1);

    // The output register can take a new beat when it is empty or when its
    // current content retires in this same cycle (full throughput).
    assign in_ready = (state == RUN) && (!mem_we || mem_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = mem_we && mem_ready;

    assign drop     = (col < k_ext);
    assign row_end  = (col == end_col);
    assign last_row = (row == h_r - WORD'(1));
    assign load     = accept && !drop;

    assign busy     = (state == RUN) || (state == DRAIN);

    // NOTE: every register below, including the output write register, is
    // cleared by the asynchronous reset so an in-flight write is abandoned
    // the instant rst falls; there is no memory array here to leave unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            h_r       <= '0;
            w_r       <= '0;
            k_r       <= '0;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every decision in
            // this cycle uses the pre-update col/row/row_base values.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        h_r      <= h;
                        w_r      <= w;
                        k_r      <= K_BITS'(n >> 1);
                        col      <= '0;
                        row      <= '0;
                        row_base <= '0;
                        done     <= 1'b0;
                        state    <= (h == '0 || w == '0) ? DONE : RUN;
                    end else if (state == DONE) begin
                        // Empty frames reach DONE with done cleared; it
                        // rises one cycle later and then holds.
                        done <= 1'b1;
                    end
                end

                RUN: begin
                    if (load) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= row_base + (col - k_ext);
                        mem_wdata <= in_data;
                    end else if (retire) begin
                        mem_we <= 1'b0;
                    end

                    if (accept) begin
                        if (row_end) begin
                            col      <= '0;
                            row      <= row + WORD'(1);
                            row_base <= row_base + w_r;
                            if (last_row) begin
                                state <= DRAIN;
                            end
                        end else begin
                            col <= col + WORD'(1);
                        end
                    end
                end

                DRAIN: begin
                    // Leave once the final write has retired (or none is
                    // pending); done then rises on the following cycle.
                    if (!mem_we || mem_ready) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wos_output_writer.sv
// ----------------------------------------------------------------------------
// tb_wos_output_writer
//
// Self-checking bench for wos_output_writer. Frame configurations live in a
// table of records carrying their expected write count and final write.
// Each accepted beat is mapped to its expected (addr, data) by the bench's
// own row/column arithmetic and pushed to a queue; every retired write pops
// and compares. Hand-written sequences cover empty frames, start pulses
// outside IDLE/DONE, and reset in the middle of a frame.
// ----------------------------------------------------------------------------
module tb_wos_output_writer;

    localparam int WORD = 32;

    typedef struct {
        int unsigned h;
        int unsigned w;
        int unsigned n;
        bit          stall;       // mem_ready pattern 1,0,0,1,...
        int          gap;         // 0: in_valid always; else valid every gap cycles
        bit          glitch;      // pulse start in the middle of RUN
        int          exp_writes;
        logic [31:0] exp_last_addr;
        logic [31:0] exp_last_data;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic [WORD-1:0] h;
    logic [WORD-1:0] w;
    logic [4:0]      n;
    logic            in_valid;
    logic [WORD-1:0] in_data;
    logic            in_ready;
    logic            mem_we;
    logic [WORD-1:0] mem_addr;
    logic [WORD-1:0] mem_wdata;
    logic            mem_ready;
    logic            busy;
    logic            done;

    int total;
    int bad;
    wr_t exp_q[$];

    wos_output_writer #(.WORD(WORD), .MAX_N(25)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .h         (h),
        .w         (w),
        .n         (n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
        check({tag, "_mem_we"},    {31'd0, mem_we},   32'd0);
        check({tag, "_mem_addr"},  mem_addr,          32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,         32'd0);
        check({tag, "_busy"},      {31'd0, busy},     32'd0);
        check({tag, "_done"},      {31'd0, done},     32'd0);
    endtask

    // Runs one frame. If abort_after > 0, returns right after that many
    // beats have been accepted, leaving the frame in flight.
    task automatic run_case(input vec_t v, input int abort_after, input string tag);
        int          beat;
        int          cyc;
        int          writes;
        int          last_retire;
        int          k;
        int          row_len;
        bit          finished;
        bit          prev_stall;
        logic [31:0] prev_addr;
        logic [31:0] prev_data;
        wr_t         last_wr;
        wr_t         exp_wr;

        k           = int'(v.n >> 1);
        row_len     = int'(v.w) + k;
        beat        = 0;
        writes      = 0;
        last_retire = -10;
        finished    = 1'b0;
        prev_stall  = 1'b0;
        prev_addr   = '0;
        prev_data   = '0;
        last_wr     = '{addr: '0, data: '0};
        exp_q.delete();

        @(negedge clk);
        start = 1'b1;
        h     = v.h;
        w     = v.w;
        n     = 5'(v.n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;

        for (cyc = 0; cyc < 600; cyc++) begin
            if (cyc != 0) @(negedge clk);
            in_valid  = (v.gap == 0) ? 1'b1 : ((cyc % v.gap) == 0);
            in_data   = beat;
            mem_ready = v.stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            // A start pulse mid-frame with different dimensions must be ignored.
            start     = v.glitch && (cyc == 5);
            h         = (v.glitch && cyc == 5) ? 32'd1 : v.h;
            w         = (v.glitch && cyc == 5) ? 32'd1 : v.w;
            #1;

            if (done) begin
                finished = 1'b1;
                check({tag, "_done_after_last_write"}, cyc, last_retire + 1);
                check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
                check({tag, "_write_count"}, writes, v.exp_writes);
                check({tag, "_queue_left"}, exp_q.size(), 0);
                check({tag, "_last_addr"}, last_wr.addr, v.exp_last_addr);
                check({tag, "_last_data"}, last_wr.data, v.exp_last_data);
                break;
            end

            if (prev_stall) begin
                check({tag, "_stall_we_held"}, {31'd0, mem_we}, 32'd1);
                check({tag, "_stall_addr_held"}, mem_addr, prev_addr);
                check({tag, "_stall_data_held"}, mem_wdata, prev_data);
            end
            if (mem_we && !mem_ready) begin
                check({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
            end
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;

            if (mem_we && mem_ready) begin
                exp_wr = (exp_q.size() > 0) ? exp_q.pop_front()
                                            : '{addr: 32'hFFFF_FFFF, data: 32'hFFFF_FFFF};
                check({tag, "_wr_addr"}, mem_addr, exp_wr.addr);
                check({tag, "_wr_data"}, mem_wdata, exp_wr.data);
                last_wr     = '{addr: mem_addr, data: mem_wdata};
                writes++;
                last_retire = cyc;
            end

            if (in_valid && in_ready) begin
                if ((beat % row_len) >= k) begin
                    exp_wr.addr = 32'((beat / row_len) * int'(v.w) + (beat % row_len) - k);
                    exp_wr.data = 32'(beat);
                    exp_q.push_back(exp_wr);
                end
                beat++;
            end

            @(posedge clk);
            if (abort_after > 0 && beat == abort_after) begin
                finished = 1'b1;
                break;
            end
        end

        start    = 1'b0;
        in_valid = 1'b0;
        if (!finished) begin
            check({tag, "_timeout"}, 32'd1, 32'd0);
        end
    endtask

    vec_t vecs[5];

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        start     = 1'b0;
        h         = '0;
        w         = '0;
        n         = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        mem_ready = 1'b1;

        //             h  w  n  stall gap glitch writes last_addr last_data
        vecs[0] = '{3, 4, 5, 1'b0, 0, 1'b0, 12, 32'd11, 32'd17};
        vecs[1] = '{2, 3, 1, 1'b0, 0, 1'b0,  6, 32'd5,  32'd5};
        vecs[2] = '{3, 4, 5, 1'b1, 0, 1'b0, 12, 32'd11, 32'd17};
        vecs[3] = '{3, 4, 5, 1'b0, 3, 1'b1, 12, 32'd11, 32'd17};
        vecs[4] = '{4, 1, 5, 1'b1, 2, 1'b0,  4, 32'd3,  32'd11};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_case(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Empty frame: w = 0 finishes with no writes, done two cycles after start.
        @(negedge clk);
        start    = 1'b1;
        h        = 32'd3;
        w        = 32'd0;
        n        = 5'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("w0_busy", {31'd0, busy}, 32'd0);
        check("w0_no_write_c1", {31'd0, mem_we}, 32'd0);
        check("w0_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("w0_done", {31'd0, done}, 32'd1);
        check("w0_no_write_c2", {31'd0, mem_we}, 32'd0);
        in_valid = 1'b0;

        // Reset with a frame in flight, then a clean rerun from address 0.
        run_case(vecs[0], 7, "abort");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        run_case(vecs[0], 0, "rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wos_output_writer.md
Name: wos_output_writer

Overview:
- Write-side counterpart of the window read-address scanner.
- The scanner walks each image row over columns 0..w+k-1, where k = n>>1, and produces one filter result per column position.
- This block accepts that result stream over a valid/ready handshake and discards the k leading partial-window results of every row.
- It writes the remaining w results per row into output memory at row-major address row*w + (col-k), then signals completion after h rows.

Parameters:
- WORD, 32, data and address width.
- MAX_N, 25, maximum window length. N_BITS = $clog2(MAX_N). K_BITS = $clog2(MAX_N>>1) + 1.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; latches h, w, n and begins a frame (honoured only in IDLE or DONE).
- h  input  WORD  image height in rows.
- w  input  WORD  image width in columns.
- n  input  N_BITS  window length; k = n>>1.
- in_valid  input  1  filter result valid.
- in_data  input  WORD  filter result.
- in_ready  output  1  block accepts in_data this cycle.
- mem_we  output  1  write request valid.
- mem_addr  output  WORD  write address.
- mem_wdata  output  WORD  write data.
- mem_ready  input  1  memory accepts the write this cycle.
- busy  output  1  frame in progress.
- done  output  1  frame complete; held until next start.

Behaviour:
- Reset: state IDLE; col=0, row=0, row_base=0; mem_we=0, mem_addr=0, mem_wdata=0; busy=0, done=0; in_ready=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE on start:
  - Latch h_r, w_r, and k_r = n>>1; clear col, row, row_base; clear done.
  - If h==0 or w==0, go to DONE (done=1 the next cycle, no writes).
  - Otherwise go to RUN.
- Handshake:
  - An input beat is accepted when in_valid & in_ready.
  - in_ready = (state==RUN) & (!mem_we | mem_ready).
  - The output is a single-entry register: mem_we/mem_addr/mem_wdata stay stable while mem_we=1 and mem_ready=0.
  - A write retires on mem_we & mem_ready.
- Accept processing, with col and row sampled before update:
  - If col < k_r: drop the beat (no write).
  - Otherwise load the output register: mem_we<=1, mem_addr<=row_base+(col-k_r), mem_wdata<=in_data.
  - If no new write is loaded and the current write retires, mem_we<=0.
  - Retire and load in the same cycle is allowed (full throughput, one beat/cycle).
- Counters on accept:
  - If col == w_r+k_r-1: col<=0, row<=row+1, row_base<=row_base+w_r. No multiplier.
  - Otherwise col<=col+1.
- Last beat: accept at row==h_r-1 and col==w_r+k_r-1 moves to DRAIN. in_ready drops the next cycle.
- DRAIN: wait until mem_we==0, or mem_we & mem_ready, then go to DONE with done=1. done rises the cycle after the final write retires.
- busy = state is RUN or DRAIN.
- Boundary conditions:
  - k_r=0 (n=0 or 1): no discards; exactly w writes per row.
  - w=1: one write per row, each preceded by k drops.
  - in_valid outside RUN is ignored and not counted.
  - start during RUN/DRAIN is ignored.
- Address arithmetic: unsigned WORD-wide, wraps modulo 2^WORD. Frames with h*w > 2^WORD are out of scope.
- Reset mid-frame: asynchronous return to the reset values. Any in-flight write is abandoned (mem_we=0 immediately).

Test Plan:
- h=3, w=4, n=5 (k=2), in_valid held high, mem_ready=1, in_data = beat index 0..17:
  - 12 writes.
  - Row 0: addr 0..3 with data 2,3,4,5. Row 1: addr 4..7 with data 8..11. Row 2: addr 8..11 with data 14..17.
  - done high 1 cycle after the last write; busy low at the same time.
- h=2, w=3, n=1 (k=0): 6 beats -> addr 0..5 in order, no drops.
- Same as the first case but mem_ready toggling 1,0,0,1,...:
  - No write lost or duplicated; mem_addr/mem_wdata stable while stalled.
  - in_ready low whenever mem_we=1 and mem_ready=0.
- in_valid gaps (valid every 3rd cycle): identical address/data sequence to the first case; col advances only on accepted beats.
- start with w=0 -> done=1 two cycles after start; no mem_we; start pulse during RUN has no effect.
- rst asserted after 7 accepted beats of the first case:
  - All outputs return to reset values.
  - A new start then produces the full correct 12-write sequence from addr 0.
